// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit driving the CPU data memory.
//   Accepts byte-addressed load/store requests on a valid/ready handshake,
//   issues word rd/wr cycles, extracts and extends sub-word loads, and does
//   sub-word stores as read-modify-write. One request in flight at a time.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_signed    store flag, 00 byte/01 half/10 word, sign-extend
//   req_addr [ADDR_W+1:0]           byte address
//   req_wdata                       right-aligned store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion pulse, load data, error
//   dm_addr/dm_rd/dm_wr/dm_wdata    word-level memory cycle
//   dm_rdata                        combinational memory read data
// Optional: define DM_LSU_ALIGN_CHECK_EN to turn misaligned or size-11 requests
// into error responses; otherwise the address is forced aligned, size 11 acts as
// word, and resp_err is tied low.
module dm_lsu #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RMW_WR, RESP} state_t;
  state_t state, nxt;

  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic              accept, acc_err, sub;
  logic [1:0]        acc_size;
  logic [ADDR_W+1:0] acc_addr;

  assign accept = req_valid & req_ready;
  // sub-word access: loads extract a lane, stores need read-modify-write
  assign sub    = (size_q != 2'b10);

`ifdef DM_LSU_ALIGN_CHECK_EN
  logic err_q;
  always_comb begin
    acc_size = req_size;
    acc_addr = req_addr;
    acc_err  = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end
`else
  always_comb begin
    acc_err  = 1'b0;
    acc_size = (req_size == 2'b11) ? 2'b10 : req_size;
    acc_addr = req_addr;
    if (acc_size == 2'b01) acc_addr[0]   = 1'b0;
    if (acc_size == 2'b10) acc_addr[1:0] = 2'b00;
  end
`endif

  // lane extraction and extension of the read word
  logic [DATA_W-1:0] shifted, load_ext, merged;
  logic [7:0]        lb;
  logic [15:0]       lh;
  assign shifted = dm_rdata >> {addr_q[1:0], 3'b000};
  assign lb      = shifted[7:0];
  assign lh      = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & lb[7]}}, lb};
      2'b01:   load_ext = {{16{sgn_q & lh[15]}}, lh};
      default: load_ext = dm_rdata;
    endcase
  end

  // read word with the target lane replaced by store data
  always_comb begin
    merged = dm_rdata;
    if (size_q == 2'b00)      merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = acc_err ? RESP : ACC;
      ACC:     nxt = (we_q && sub) ? RMW_WR : RESP;
      RMW_WR:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs decoded from state so reset drops the strobes at once
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    dm_rd      = (state == ACC) && (!we_q || sub);
    dm_wr      = ((state == ACC) && we_q && !sub) || (state == RMW_WR);
`ifdef DM_LSU_ALIGN_CHECK_EN
    resp_err   = (state == RESP) && err_q;
`else
    resp_err   = 1'b0;
`endif
  end

  assign resp_rdata = rdata_q;
  assign dm_addr    = addr_q[ADDR_W+1:2];
  // wdata_q holds the store data, then the merged word once an RMW read completes
  assign dm_wdata   = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DM_LSU_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      size_q  <= acc_size;
      addr_q  <= acc_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
`ifdef DM_LSU_ALIGN_CHECK_EN
      err_q   <= acc_err;
`endif
    end else if (state == ACC) begin
      if (!we_q)    rdata_q <= load_ext;
      else if (sub) wdata_q <= merged;
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a 128-word memory model that powers up all-ones.
module tb_dm_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  dm_addr;
  logic        dm_rd, dm_wr;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem [0:127];
  int vecs = 0;
  int errs = 0;

  // per-transaction observations filled by do_req
  logic [31:0] o_rdata, o_wdat;
  logic        o_err;
  logic [6:0]  o_addr;
  int          o_lat, o_rdn, o_wrn, o_rdat, o_wrat;

  dm_lsu #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

  // Drive one request, then sample at each negedge after the accept edge (k=1 is
  // the first cycle after accept) until resp_valid or a cycle bound.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    o_lat = -1; o_rdn = 0; o_wrn = 0; o_rdat = -1; o_wrat = -1;
    o_rdata = 32'hDEAD_BEEF; o_err = 1'bx; o_wdat = '0; o_addr = '1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (dm_rd) begin o_rdn++; if (o_rdat < 0) o_rdat = k; o_addr = dm_addr; end
      if (dm_wr) begin o_wrn++; o_wrat = k; o_wdat = dm_wdata; o_addr = dm_addr; end
      if (resp_valid) begin o_lat = k; o_rdata = resp_rdata; o_err = resp_err; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    vecs++; if ({resp_valid, resp_err, dm_rd, dm_wr} !== 4'b0000) begin errs++; $display("FAIL rst_strobes: got %b want 0000", {resp_valid, resp_err, dm_rd, dm_wr}); end
    vecs++; if (resp_rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    vecs++; if (dm_addr !== 7'h0 || dm_wdata !== 32'h0) begin errs++; $display("FAIL rst_dm: got addr %h wdata %h want 0/0", dm_addr, dm_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_load;
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    vecs++; if (o_lat !== 2) begin errs++; $display("FAIL lw_latency: got %0d want 2", o_lat); end
    vecs++; if (o_rdn !== 1 || o_wrn !== 0) begin errs++; $display("FAIL lw_strobes: got rd %0d wr %0d want 1/0", o_rdn, o_wrn); end
    vecs++; if (o_addr !== 7'd4) begin errs++; $display("FAIL lw_addr: got %0d want 4", o_addr); end
    vecs++; if (o_rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL lw_data: got %h want ffffffff", o_rdata); end
  endtask

  task automatic test_store_load;
    do_req(1'b1, 2'b10, 1'b0, 9'h020, 32'h1234_5678);
    vecs++; if (o_lat !== 2 || o_wrn !== 1 || o_rdn !== 0) begin errs++; $display("FAIL sw_timing: got lat %0d wr %0d rd %0d want 2/1/0", o_lat, o_wrn, o_rdn); end
    vecs++; if (o_wdat !== 32'h1234_5678 || o_addr !== 7'd8) begin errs++; $display("FAIL sw_wdata: got %h @%0d want 12345678 @8", o_wdat, o_addr); end
    vecs++; if (o_rdata !== 32'h0 || mem[8] !== 32'h1234_5678) begin errs++; $display("FAIL sw_mem: got rdata %h mem %h want 0/12345678", o_rdata, mem[8]); end
    do_req(1'b0, 2'b00, 1'b1, 9'h021, 32'h0);
    vecs++; if (o_rdata !== 32'h0000_0056) begin errs++; $display("FAIL lb_21: got %h want 00000056", o_rdata); end
    do_req(1'b0, 2'b00, 1'b0, 9'h023, 32'h0);
    vecs++; if (o_rdata !== 32'h0000_0012) begin errs++; $display("FAIL lbu_23: got %h want 00000012", o_rdata); end
    do_req(1'b0, 2'b01, 1'b1, 9'h022, 32'h0);
    vecs++; if (o_rdata !== 32'h0000_1234) begin errs++; $display("FAIL lh_22: got %h want 00001234", o_rdata); end
  endtask

  task automatic test_rmw;
    do_req(1'b1, 2'b00, 1'b0, 9'h041, 32'h0000_0080);
    vecs++; if (o_rdat !== 1 || o_wrat !== 2 || o_lat !== 3) begin errs++; $display("FAIL sb_timing: got rd@%0d wr@%0d resp@%0d want 1/2/3", o_rdat, o_wrat, o_lat); end
    vecs++; if (o_wdat !== 32'hFFFF_80FF || o_addr !== 7'h10) begin errs++; $display("FAIL sb_merge: got %h @%h want ffff80ff @10", o_wdat, o_addr); end
    vecs++; if (o_rdn !== 1 || o_wrn !== 1) begin errs++; $display("FAIL sb_strobes: got rd %0d wr %0d want 1/1", o_rdn, o_wrn); end
    do_req(1'b0, 2'b01, 1'b1, 9'h040, 32'h0);
    vecs++; if (o_rdata !== 32'hFFFF_80FF) begin errs++; $display("FAIL lh_40: got %h want ffff80ff", o_rdata); end
    do_req(1'b0, 2'b00, 1'b1, 9'h041, 32'h0);
    vecs++; if (o_rdata !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_41: got %h want ffffff80", o_rdata); end
    do_req(1'b0, 2'b00, 1'b0, 9'h041, 32'h0);
    vecs++; if (o_rdata !== 32'h0000_0080) begin errs++; $display("FAIL lbu_41: got %h want 00000080", o_rdata); end
    do_req(1'b1, 2'b01, 1'b0, 9'h046, 32'hABCD_1234);
    vecs++; if (o_wdat !== 32'h1234_FFFF || mem[17] !== 32'h1234_FFFF) begin errs++; $display("FAIL sh_46: got %h mem %h want 1234ffff", o_wdat, mem[17]); end
  endtask

  task automatic test_align;
    do_req(1'b1, 2'b10, 1'b0, 9'h000, 32'h8765_4321);
    do_req(1'b0, 2'b01, 1'b1, 9'h003, 32'h0);
`ifdef DM_LSU_ALIGN_CHECK_EN
    vecs++; if (o_err !== 1'b1 || o_lat !== 1) begin errs++; $display("FAIL lh_mis_err: got err %b lat %0d want 1/1", o_err, o_lat); end
    vecs++; if (o_rdn !== 0 || o_wrn !== 0 || o_rdata !== 32'h0) begin errs++; $display("FAIL lh_mis_quiet: got rd %0d wr %0d data %h want 0/0/0", o_rdn, o_wrn, o_rdata); end
    do_req(1'b0, 2'b11, 1'b0, 9'h020, 32'h0);
    vecs++; if (o_err !== 1'b1 || o_lat !== 1 || o_rdn !== 0) begin errs++; $display("FAIL sz11_err: got err %b lat %0d rd %0d want 1/1/0", o_err, o_lat, o_rdn); end
`else
    vecs++; if (o_err !== 1'b0 || o_lat !== 2 || o_addr !== 7'd0) begin errs++; $display("FAIL lh_force: got err %b lat %0d addr %0d want 0/2/0", o_err, o_lat, o_addr); end
    vecs++; if (o_rdata !== 32'hFFFF_8765) begin errs++; $display("FAIL lh_force_data: got %h want ffff8765", o_rdata); end
    do_req(1'b0, 2'b11, 1'b0, 9'h020, 32'h0);
    vecs++; if (o_err !== 1'b0 || o_rdata !== 32'h1234_5678) begin errs++; $display("FAIL sz11_word: got err %b data %h want 0/12345678", o_err, o_rdata); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [8:0]  a_l [3];
    logic [1:0]  s_l [3];
    logic [31:0] e_l [3];
    int idx = 0, accepts = 0, resps = 0, busy_rdy = 0;
    logic acc;
    a_l[0] = 9'h020; s_l[0] = 2'b10; e_l[0] = 32'h1234_5678;
    a_l[1] = 9'h041; s_l[1] = 2'b00; e_l[1] = 32'h0000_0080;
    a_l[2] = 9'h010; s_l[2] = 2'b10; e_l[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_signed = 1'b0; req_wdata = '0;
    req_addr = a_l[0]; req_size = s_l[0];
    for (int c = 0; c < 40 && resps < 3; c++) begin
      acc = req_valid && req_ready;
      if (acc) accepts++;
      if (req_ready && (dm_rd || dm_wr || resp_valid)) busy_rdy++;
      if (resp_valid) begin
        vecs++; if (resp_rdata !== e_l[resps]) begin errs++; $display("FAIL b2b_data%0d: got %h want %h", resps, resp_rdata, e_l[resps]); end
        resps++;
      end
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) begin req_addr = a_l[idx]; req_size = s_l[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    vecs++; if (accepts !== 3 || resps !== 3) begin errs++; $display("FAIL b2b_count: got acc %0d resp %0d want 3/3", accepts, resps); end
    vecs++; if (busy_rdy !== 0) begin errs++; $display("FAIL b2b_ready_busy: got %0d cycles want 0", busy_rdy); end
  endtask

  task automatic test_reset_rmw;
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 9'h061; req_wdata = 32'h0000_0011;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vecs++; if (dm_rd !== 1'b1) begin errs++; $display("FAIL rr_acc_rd: got %b want 1", dm_rd); end
    @(posedge clk); #1;
    vecs++; if (dm_wr !== 1'b1 || dm_wdata !== 32'hFFFF_11FF) begin errs++; $display("FAIL rr_wr: got %b %h want 1 ffff11ff", dm_wr, dm_wdata); end
    rst_n = 1'b0; #1;
    vecs++; if (dm_wr !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin errs++; $display("FAIL rr_drop: got wr %b rdy %b rv %b want 0/1/0", dm_wr, req_ready, resp_valid); end
    @(posedge clk); #1;
    vecs++; if (mem[24] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rr_mem: got %h want ffffffff", mem[24]); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid) pulses++; end
    vecs++; if (pulses !== 0) begin errs++; $display("FAIL rr_noresp: got %0d pulses want 0", pulses); end
    do_req(1'b0, 2'b10, 1'b0, 9'h060, 32'h0);
    vecs++; if (o_rdata !== 32'hFFFF_FFFF || o_lat !== 2) begin errs++; $display("FAIL rr_after: got %h lat %0d want ffffffff/2", o_rdata, o_lat); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    test_reset;
    test_word_load;
    test_store_load;
    test_rmw;
    test_align;
    test_back_to_back;
    test_reset_rmw;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
